// File: rtl/word_packer.sv
// word_packer: packs NUM_WORDS narrow words, first word in the MSBs.
// Valid/ready on both sides, output backpressure and partial flush.
module word_packer #(
    parameter int WORD_W    = 4,
    parameter int NUM_WORDS = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [WORD_W-1:0]                    in_data_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic                                 flush_i,
    output logic [WORD_W*NUM_WORDS-1:0]          out_data_o,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [$clog2(NUM_WORDS+1)-1:0]       out_count_o
);

    localparam int OUT_W = WORD_W * NUM_WORDS;
    localparam int CW    = $clog2(NUM_WORDS + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);

    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] acc_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    held;
    logic             slot_free;
    logic             accept;
    logic             full;
    logic             emit;

    always_comb begin
        slot_free  = !out_valid_o || out_ready_i;
        in_ready_o = (cnt != LAST) || slot_free;
        accept     = in_valid_i && in_ready_o;
        acc_next   = acc;
        if (accept) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (cnt == CW'(i))
                    acc_next[OUT_W-1-i*WORD_W -: WORD_W] = in_data_i;
            end
        end
        held = cnt + CW'(accept);
        full = accept && (cnt == LAST);
        // a flush also picks up a word accepted in the same cycle
        emit = full || (flush_i && slot_free && (held != '0));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc         <= '0;
            cnt         <= '0;
            out_data_o  <= '0;
            out_count_o <= '0;
            out_valid_o <= 1'b0;
        end else if (emit) begin
            out_data_o  <= acc_next;
            out_count_o <= held;
            out_valid_o <= 1'b1;
            acc         <= '0;
            cnt         <= '0;
        end else begin
            if (accept) begin
                acc <= acc_next;
                cnt <= held;
            end
            if (out_valid_o && out_ready_i)
                out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_word_packer.sv
// Bench for word_packer: directed cases plus a random stream
// checked against a queue-based packet model.
module tb_word_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] a_data   = '0;
    logic       a_valid  = 1'b0;
    logic       a_flush  = 1'b0;
    logic       a_oready = 1'b1;
    logic       a_ready;
    logic [7:0] a_odata;
    logic       a_ovalid;
    logic [1:0] a_ocount;

    logic [3:0]  b_data   = '0;
    logic        b_valid  = 1'b0;
    logic        b_flush  = 1'b0;
    logic        b_oready = 1'b1;
    logic        b_ready;
    logic [15:0] b_odata;
    logic        b_ovalid;
    logic [2:0]  b_ocount;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int         pend[$];
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = '0;
    logic [1:0] m_count = '0;

    always #5 clk = ~clk;

    word_packer u_a (
        .clk_i(clk), .rst_i(rst),
        .in_data_i(a_data), .in_valid_i(a_valid), .in_ready_o(a_ready),
        .flush_i(a_flush),
        .out_data_o(a_odata), .out_valid_o(a_ovalid),
        .out_ready_i(a_oready), .out_count_o(a_ocount)
    );

    word_packer #(.WORD_W(4), .NUM_WORDS(4)) u_b (
        .clk_i(clk), .rst_i(rst),
        .in_data_i(b_data), .in_valid_i(b_valid), .in_ready_o(b_ready),
        .flush_i(b_flush),
        .out_data_o(b_odata), .out_valid_o(b_ovalid),
        .out_ready_i(b_oready), .out_count_o(b_ocount)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pack(input int q[$]);
        logic [7:0] p = '0;
        for (int i = 0; i < q.size(); i++)
            p = p | (8'(q[i] & 15) << (4 * (1 - i)));
        return p;
    endfunction

    // one cycle on the 2-word packer, called at a falling edge
    task automatic cyc(input logic v, input logic [3:0] d,
                       input logic f, input logic r);
        logic exp_ready;
        logic free;
        logic emit;
        a_valid  = v;
        a_data   = d;
        a_flush  = f;
        a_oready = r;
        #1;
        exp_ready = (pend.size() != 1) || !m_valid || r;
        chk("in_ready", 32'(a_ready), 32'(exp_ready));
        chk("out_valid", 32'(a_ovalid), 32'(m_valid));
        chk("out_data", 32'(a_odata), 32'(m_data));
        chk("out_count", 32'(a_ocount), 32'(m_count));
        free = !m_valid || r;
        if (v && exp_ready) pend.push_back(int'(d));
        emit = (pend.size() == 2) || (f && free && pend.size() > 0);
        if (emit) begin
            m_data  = pack(pend);
            m_count = 2'(pend.size());
            m_valid = 1'b1;
            pend.delete();
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic bcyc(input logic v, input logic [3:0] d,
                        input logic f, input logic r);
        b_valid  = v;
        b_data   = d;
        b_flush  = f;
        b_oready = r;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        #1;
        chk("rst_a_data", 32'(a_odata), 32'h0);
        chk("rst_a_valid", 32'(a_ovalid), 32'h0);
        chk("rst_a_count", 32'(a_ocount), 32'h0);
        chk("rst_a_ready", 32'(a_ready), 32'h1);
        chk("rst_b_ready", 32'(b_ready), 32'h1);
        chk("rst_b_valid", 32'(b_ovalid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 4-word packer: flush of a single word, then a full packet
        bcyc(1'b1, 4'h3, 1'b0, 1'b1);
        bcyc(1'b0, 4'h0, 1'b1, 1'b1);
        chk("b_flush1_valid", 32'(b_ovalid), 32'h1);
        chk("b_flush1_data", 32'(b_odata), 32'h3000);
        chk("b_flush1_count", 32'(b_ocount), 32'h1);
        bcyc(1'b1, 4'h9, 1'b0, 1'b1);
        bcyc(1'b1, 4'h8, 1'b0, 1'b1);
        bcyc(1'b1, 4'h7, 1'b0, 1'b1);
        chk("b_partial_novalid", 32'(b_ovalid), 32'h0);
        bcyc(1'b1, 4'h6, 1'b0, 1'b1);
        chk("b_full_data", 32'(b_odata), 32'h9876);
        chk("b_full_count", 32'(b_ocount), 32'h4);
        chk("b_full_valid", 32'(b_ovalid), 32'h1);
        // flush in the same cycle as an accept
        bcyc(1'b1, 4'hC, 1'b0, 1'b1);
        bcyc(1'b1, 4'hD, 1'b1, 1'b1);
        chk("b_flush2_data", 32'(b_odata), 32'hCD00);
        chk("b_flush2_count", 32'(b_ocount), 32'h2);
        chk("b_flush2_valid", 32'(b_ovalid), 32'h1);
        bcyc(1'b0, 4'h0, 1'b1, 1'b1);
        chk("b_empty_flush", 32'(b_ovalid), 32'h0);
        bcyc(1'b0, 4'h0, 1'b0, 1'b1);

        // 2-word packer: basic pair
        cyc(1'b1, 4'hA, 1'b0, 1'b1);
        cyc(1'b1, 4'h5, 1'b0, 1'b1);
        chk("a_pair_data", 32'(a_odata), 32'hA5);
        chk("a_pair_count", 32'(a_ocount), 32'h2);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        chk("a_pair_one_cycle", 32'(a_ovalid), 32'h0);

        // backpressure: held packet, stalled last word, no bubble
        cyc(1'b1, 4'h1, 1'b0, 1'b0);
        cyc(1'b1, 4'h2, 1'b0, 1'b0);
        chk("a_bp_hold1", 32'(a_odata), 32'h12);
        cyc(1'b1, 4'h3, 1'b0, 1'b0);
        chk("a_bp_stall_ready", 32'(a_ready), 32'h0);
        cyc(1'b1, 4'h4, 1'b0, 1'b0);
        chk("a_bp_hold2", 32'(a_odata), 32'h12);
        cyc(1'b1, 4'h4, 1'b0, 1'b1);
        chk("a_bp_next_data", 32'(a_odata), 32'h34);
        chk("a_bp_next_valid", 32'(a_ovalid), 32'h1);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);

        // asynchronous reset with a held packet and a partial one
        cyc(1'b1, 4'hF, 1'b0, 1'b0);
        cyc(1'b1, 4'hE, 1'b0, 1'b0);
        cyc(1'b1, 4'hD, 1'b0, 1'b0);
        chk("a_pre_rst_data", 32'(a_odata), 32'hFE);
        #2 rst = 1'b1;
        #1;
        chk("a_async_data", 32'(a_odata), 32'h0);
        chk("a_async_valid", 32'(a_ovalid), 32'h0);
        chk("a_async_count", 32'(a_ocount), 32'h0);
        chk("a_async_ready", 32'(a_ready), 32'h1);
        a_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pend.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_count = '0;
        cyc(1'b1, 4'h2, 1'b0, 1'b1);
        cyc(1'b1, 4'h1, 1'b0, 1'b1);
        chk("a_post_rst_data", 32'(a_odata), 32'h21);
        chk("a_post_rst_count", 32'(a_ocount), 32'h2);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);

        // random stream against the packet model
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom % 4) != 0, 4'($urandom % 16),
                ($urandom % 5) == 0, ($urandom % 3) != 0);
        end
        for (int n = 0; n < 4; n++)
            cyc(1'b0, 4'h0, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
